accum_sequencer: RTL and testbench

- Control FSM that sequences a shared streaming complex accumulator.
- The datapath is a complexAdd pipeline plus a MAX_LEN-deep complex_t partial-sum buffer.
- The block sums K frames of N complex bins element-wise.
- It generates buffer read/write addresses, the first-frame zero-operand select, adder-valid, final-output-valid and run status. It holds no data.

---
 rtl/accum_sequencer_pkg.sv | 24 ++
 rtl/accum_sequencer_shift_reg.sv | 34 +++
 rtl/accum_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_accum_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/accum_sequencer_pkg.sv
// Shared types and constants for the streaming complex accumulator sequencer.
package accum_sequencer_pkg;

    localparam int MAX_LEN_DEFAULT = 512;
    localparam int ADD_LAT_DEFAULT = 6;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } accum_state_t;

    // The write-back of bin j must land before bin j is read again in the next frame.
    function automatic int min_legal_len(input int add_lat);
        return (add_lat + 2 > 8) ? add_lat + 2 : 8;
    endfunction

endpackage

// File: rtl/accum_sequencer_shift_reg.sv
// Fixed-depth shift register with asynchronous reset; carries per-sample tags
// alongside the adder pipeline.
module shift_reg_fifo_rst #(
    parameter int DEPTH = 7,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: every stage is reset, so no stale valid bit can emerge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/accum_sequencer.sv
// Control FSM for a shared streaming complex accumulator: sums K frames of N
// bins, driving buffer addressing, adder controls and run status.
module accum_sequencer
    import accum_sequencer_pkg::*;
#(
    parameter int LEN_W   = 10,
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int ADDR_W  = 9,
    parameter int FRM_W   = 8,
    parameter int ADD_LAT = ADD_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              config_valid,
    input  logic [LEN_W-1:0]  config_length,
    input  logic [FRM_W-1:0]  config_frames,
    output logic              config_ready,
    output logic              cfg_err,
    input  logic              start,
    input  logic              in_valid,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              add_valid,
    output logic              add_sel_zero,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err_overrun
);

    localparam int MIN_LEN = min_legal_len(ADD_LAT);
    localparam int DL_W    = ADDR_W + 2;

    accum_state_t      state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [FRM_W-1:0]  frames_q, frames_d;
    logic              loaded_q, loaded_d;
    logic              cfg_err_q, cfg_err_d;
    logic [ADDR_W-1:0] bin_q, bin_d;
    logic [FRM_W-1:0]  frm_q, frm_d;
    logic              add_valid_q, add_valid_d;
    logic              add_sel_zero_q, add_sel_zero_d;
    logic              done_q, done_d;
    logic              err_overrun_q, err_overrun_d;

    logic              cfg_legal;
    logic              sample;
    logic              last_bin;
    logic              last_frm;
    logic [DL_W-1:0]   dl_in;
    logic [DL_W-1:0]   dl_out;
    logic              dl_valid;
    logic              dl_final;
    logic [ADDR_W-1:0] dl_addr;

    assign sample   = in_valid && (state_q == ST_RUN);
    assign last_bin = (LEN_W'(bin_q) == len_q - LEN_W'(1));
    assign last_frm = (frm_q == frames_q - FRM_W'(1));
    assign cfg_legal = (int'(config_length) >= MIN_LEN) &&
                       (int'(config_length) <= MAX_LEN) &&
                       (config_frames != '0);

    assign dl_in    = {sample, last_frm, bin_q};
    assign dl_valid = dl_out[DL_W-1];
    assign dl_final = dl_out[DL_W-2];
    assign dl_addr  = dl_out[ADDR_W-1:0];

    shift_reg_fifo_rst #(
        .DEPTH (ADD_LAT + 1),
        .WIDTH (DL_W)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .din   (dl_in),
        .dout  (dl_out)
    );

    // NOTE: each variable gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        frames_d       = frames_q;
        loaded_d       = loaded_q;
        cfg_err_d      = cfg_err_q;
        bin_d          = bin_q;
        frm_d          = frm_q;
        add_valid_d    = sample;
        add_sel_zero_d = sample && (frm_q == '0);
        done_d         = 1'b0;
        err_overrun_d  = err_overrun_q || (in_valid && (state_q != ST_RUN));

        unique case (state_q)
            ST_IDLE: begin
                if (config_valid) begin
                    cfg_err_d = !cfg_legal;
                    loaded_d  = cfg_legal;
                    if (cfg_legal) begin
                        len_d    = config_length;
                        frames_d = config_frames;
                    end
                end
                // A same-cycle config decides whether this start is honoured.
                if (start && (config_valid ? cfg_legal : loaded_q)) begin
                    state_d       = ST_RUN;
                    bin_d         = '0;
                    frm_d         = '0;
                    err_overrun_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (sample) begin
                    if (last_bin) begin
                        bin_d = '0;
                        if (last_frm) begin
                            state_d = ST_DRAIN;
                        end else begin
                            frm_d = frm_q + FRM_W'(1);
                        end
                    end else begin
                        bin_d = bin_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (out_last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            frames_q       <= '0;
            loaded_q       <= 1'b0;
            cfg_err_q      <= 1'b0;
            bin_q          <= '0;
            frm_q          <= '0;
            add_valid_q    <= 1'b0;
            add_sel_zero_q <= 1'b0;
            done_q         <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            frames_q       <= frames_d;
            loaded_q       <= loaded_d;
            cfg_err_q      <= cfg_err_d;
            bin_q          <= bin_d;
            frm_q          <= frm_d;
            add_valid_q    <= add_valid_d;
            add_sel_zero_q <= add_sel_zero_d;
            done_q         <= done_d;
            err_overrun_q  <= err_overrun_d;
        end
    end

    assign config_ready = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign cfg_err      = cfg_err_q;
    assign rd_en        = sample && (frm_q != '0);
    assign rd_addr      = bin_q;
    assign add_valid    = add_valid_q;
    assign add_sel_zero = add_sel_zero_q;
    assign wr_en        = dl_valid && !dl_final;
    assign wr_addr      = dl_addr;
    assign out_valid    = dl_valid && dl_final;
    assign out_last     = out_valid && (LEN_W'(dl_addr) == len_q - LEN_W'(1));
    assign done         = done_q;
    assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_accum_sequencer.sv
// Directed self-checking bench for accum_sequencer: one sample point per cycle,
// expectations derived from cycle offsets relative to the first RUN cycle.
module tb_accum_sequencer;

    localparam int LEN_W  = 10;
    localparam int ADDR_W = 9;
    localparam int FRM_W  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              config_valid = 1'b0;
    logic [LEN_W-1:0]  config_length = '0;
    logic [FRM_W-1:0]  config_frames = '0;
    logic              config_ready;
    logic              cfg_err;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              add_valid;
    logic              add_sel_zero;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err_overrun;

    int n_assert = 0;
    int n_fail   = 0;

    accum_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .config_valid  (config_valid),
        .config_length (config_length),
        .config_frames (config_frames),
        .config_ready  (config_ready),
        .cfg_err       (cfg_err),
        .start         (start),
        .in_valid      (in_valid),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .add_valid     (add_valid),
        .add_sel_zero  (add_sel_zero),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done),
        .err_overrun   (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle before sampling.
    task automatic drive(input logic iv, input logic cv, input int len, input int frm, input logic st);
        @(negedge clk);
        in_valid      = iv;
        config_valid  = cv;
        config_length = LEN_W'(len);
        config_frames = FRM_W'(frm);
        start         = st;
        #1;
    endtask

    int bad_len [3] = '{7, 513, 8};
    int bad_frm [3] = '{2, 1, 0};

    initial begin
        logic seen;

        // Reset state
        #1 reset = 1'b1;
        #1;
        check_bit("rst_config_ready", config_ready, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_cfg_err", cfg_err, 1'b0);
        check_bit("rst_wr_en", wr_en, 1'b0);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // 1: N=8, K=1, back-to-back samples
        drive(1'b0, 1'b1, 8, 1, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        for (int c = 0; c < 18; c++) begin
            drive(c < 8, 1'b0, 0, 0, 1'b0);
            check_bit("t1_sel_zero", add_sel_zero, c >= 1 && c <= 8);
            check_bit("t1_add_valid", add_valid, c >= 1 && c <= 8);
            check_bit("t1_rd_en", rd_en, 1'b0);
            check_bit("t1_wr_en", wr_en, 1'b0);
            check_bit("t1_out_valid", out_valid, c >= 7 && c <= 14);
            check_bit("t1_out_last", out_last, c == 14);
            check_bit("t1_done", done, c == 15);
            check_bit("t1_busy", busy, c <= 15);
            check_bit("t1_config_ready", config_ready, c >= 16);
        end

        // 2: N=16, K=3, continuous
        drive(1'b0, 1'b1, 16, 3, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        for (int c = 0; c < 58; c++) begin
            drive(c < 48, 1'b0, 0, 0, 1'b0);
            check_bit("t2_rd_en", rd_en, c >= 16 && c < 48);
            if (c < 48) check_val("t2_rd_addr", 32'(rd_addr), c % 16);
            check_bit("t2_wr_en", wr_en, c >= 7 && c <= 38);
            check_bit("t2_out_valid", out_valid, c >= 39 && c <= 54);
            if (c >= 7 && c <= 54) check_val("t2_wr_addr", 32'(wr_addr), (c - 7) % 16);
            check_bit("t2_out_last", out_last, c == 54);
            check_bit("t2_sel_zero", add_sel_zero, c >= 1 && c <= 16);
            check_bit("t2_done", done, c == 55);
        end

        // 3: illegal configs block the following start
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, bad_len[i], bad_frm[i], 1'b0);
            drive(1'b0, 1'b0, 0, 0, 1'b1);
            check_bit("t3_cfg_err", cfg_err, 1'b1);
            drive(1'b0, 1'b0, 0, 0, 1'b0);
            check_bit("t3_busy", busy, 1'b0);
            check_bit("t3_config_ready", config_ready, 1'b1);
        end
        drive(1'b0, 1'b1, 8, 1, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        check_bit("t3_cfg_err_clear", cfg_err, 1'b0);

        // 4: N=8, K=2, config and start together, samples every other cycle
        drive(1'b0, 1'b1, 8, 2, 1'b1);
        for (int c = 0; c < 41; c++) begin
            drive((c % 2 == 0) && c <= 30, 1'b0, 0, 0, 1'b0);
            check_bit("t4_rd_en", rd_en, (c % 2 == 0) && c >= 16 && c <= 30);
            if ((c % 2 == 0) && c <= 30) check_val("t4_rd_addr", 32'(rd_addr), (c / 2) % 8);
            check_bit("t4_wr_en", wr_en, (c % 2 == 1) && c >= 7 && c <= 21);
            check_bit("t4_out_valid", out_valid, (c % 2 == 1) && c >= 23 && c <= 37);
            if ((c % 2 == 1) && c >= 7 && c <= 37)
                check_val("t4_wr_addr", 32'(wr_addr), ((c - 7) / 2) % 8);
            check_bit("t4_out_last", out_last, c == 37);
            check_bit("t4_add_valid", add_valid, (c % 2 == 1) && c <= 31);
            check_bit("t4_sel_zero", add_sel_zero, (c % 2 == 1) && c <= 15);
            check_bit("t4_done", done, c == 38);
        end

        // 5: reset in frame 1 of an N=16, K=4 run
        drive(1'b0, 1'b1, 16, 4, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b0, 0, 0, 1'b0);
        end
        check_bit("t5_pre_wr_en", wr_en, 1'b1);
        check_val("t5_pre_wr_addr", 32'(wr_addr), 12);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check_bit("t5_config_ready", config_ready, 1'b1);
        check_bit("t5_busy", busy, 1'b0);
        check_bit("t5_rd_en", rd_en, 1'b0);
        check_val("t5_rd_addr", 32'(rd_addr), 0);
        check_bit("t5_add_valid", add_valid, 1'b0);
        check_bit("t5_sel_zero", add_sel_zero, 1'b0);
        check_bit("t5_wr_en", wr_en, 1'b0);
        check_val("t5_wr_addr", 32'(wr_addr), 0);
        check_bit("t5_out_valid", out_valid, 1'b0);
        check_bit("t5_out_last", out_last, 1'b0);
        check_bit("t5_done", done, 1'b0);
        check_bit("t5_cfg_err", cfg_err, 1'b0);
        check_bit("t5_err_overrun", err_overrun, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 1'b0, 0, 0, 1'b0);
            check_bit("t5_post_wr_en", wr_en, 1'b0);
            check_bit("t5_post_out_valid", out_valid, 1'b0);
        end
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 0, 0, 1'b0);
            check_bit("t5_start_ignored", busy, 1'b0);
        end

        // 6: config during RUN ignored, sample during DRAIN flags overrun
        drive(1'b0, 1'b1, 16, 1, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        for (int c = 0; c < 26; c++) begin
            drive(c < 16 || c == 18, c == 3, 32, 1, 1'b0);
            check_bit("t6_rd_en", rd_en, 1'b0);
            check_bit("t6_wr_en", wr_en, 1'b0);
            check_bit("t6_out_valid", out_valid, c >= 7 && c <= 22);
            if (c >= 7 && c <= 22) check_val("t6_wr_addr", 32'(wr_addr), c - 7);
            check_bit("t6_out_last", out_last, c == 22);
            check_bit("t6_done", done, c == 23);
            check_bit("t6_err_overrun", err_overrun, c >= 19);
            check_bit("t6_cfg_err", cfg_err, 1'b0);
        end
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 0, 0, 1'b0);
            if (i == 0) check_bit("t6_overrun_cleared", err_overrun, 1'b0);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            drive(1'b0, 1'b0, 0, 0, 1'b0);
            if (done) seen = 1'b1;
        end
        check_bit("t6_rerun_done", seen, 1'b1);
        check_bit("t6_rerun_overrun", err_overrun, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
